// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, interrupt cause codes and trap sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MIE    = 12'h304;
    localparam logic [11:0] CSR_MIP    = 12'h344;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SAVE,
        ST_REDIRECT,
        ST_MRET_FLUSH
    } trap_state_t;

    function automatic logic [31:0] mip_word(input logic meip, input logic mtip, input logic msip);
        return {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};
    endfunction

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// Commit-stage / CSR-file connection of the machine-mode trap sequencer.
// Latency: n/a (wiring only).
// Backpressure: stall_out holds the commit side for the whole sequence.
interface irq_trap_ctrl_if;
    logic        meie_in, mtie_in, msie_in;
    logic        mstatus_mie_in;
    logic        ext_irq_in, timer_irq_in, sw_irq_in;
    logic        instr_valid_in;
    logic [31:0] pc_in;
    logic        exception_in;
    logic [3:0]  exc_cause_in;
    logic        mret_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;

    logic [31:0] mip_out;
    logic        stall_out;
    logic        flush_out;
    logic        mepc_wr_en_out;
    logic [31:0] mepc_out;
    logic        mcause_wr_en_out;
    logic [31:0] mcause_out;
    logic        mstatus_trap_out;
    logic        mstatus_mret_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;

    modport master (
        output meie_in, mtie_in, msie_in, mstatus_mie_in,
        output ext_irq_in, timer_irq_in, sw_irq_in,
        output instr_valid_in, pc_in, exception_in, exc_cause_in, mret_in,
        output mtvec_in, mepc_in,
        input  mip_out, stall_out, flush_out,
        input  mepc_wr_en_out, mepc_out, mcause_wr_en_out, mcause_out,
        input  mstatus_trap_out, mstatus_mret_out,
        input  redirect_valid_out, redirect_pc_out
    );

    modport slave (
        input  meie_in, mtie_in, msie_in, mstatus_mie_in,
        input  ext_irq_in, timer_irq_in, sw_irq_in,
        input  instr_valid_in, pc_in, exception_in, exc_cause_in, mret_in,
        input  mtvec_in, mepc_in,
        output mip_out, stall_out, flush_out,
        output mepc_wr_en_out, mepc_out, mcause_wr_en_out, mcause_out,
        output mstatus_trap_out, mstatus_mret_out,
        output redirect_valid_out, redirect_pc_out
    );
endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for one asynchronous interrupt line.
// Latency: STAGES clocks from input edge to output.
// Backpressure: none.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_in,
    input  logic async_in,
    output logic sync_out
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (rst_in) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];
endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap/MRET sequencer: picks exception > interrupt > mret at commit, writes mepc/mcause, redirects fetch.
// Latency: trap redirect 3 clocks after detection, MRET redirect 2 clocks after detection.
// Backpressure: stall_out high in every non-idle state; commit inputs are ignored meanwhile.
module irq_trap_ctrl
    import riscv_csr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input logic            clock,
    input logic            rst_in,
    irq_trap_ctrl_if.slave bus
);
    logic ext_sync, timer_sync, sw_sync;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext   (.clock(clock), .rst_in(rst_in), .async_in(bus.ext_irq_in),   .sync_out(ext_sync));
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (.clock(clock), .rst_in(rst_in), .async_in(bus.timer_irq_in), .sync_out(timer_sync));
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw    (.clock(clock), .rst_in(rst_in), .async_in(bus.sw_irq_in),    .sync_out(sw_sync));

    logic       meip, mtip, msip, irq_take;
    logic [3:0] irq_code;

    assign meip     = ext_sync & bus.meie_in;
    assign mtip     = timer_sync & bus.mtie_in;
    assign msip     = sw_sync & bus.msie_in;
    assign irq_take = bus.mstatus_mie_in & (meip | mtip | msip);

    // Interrupt priority is MEI > MSI > MTI, not numeric order.
    always_comb begin
        if (meip)      irq_code = IRQ_MEI;
        else if (msip) irq_code = IRQ_MSI;
        else           irq_code = IRQ_MTI;
    end

    logic [31:0] mtvec_base, vec_offset;
    assign mtvec_base = bus.mtvec_in & ~32'd3;
    assign vec_offset = (VECTORED_EN && bus.mtvec_in[0]) ? {26'd0, irq_code, 2'b00} : 32'd0;

    trap_state_t state, state_nxt;
    logic [31:0] cause_q, mepc_q, target_q;
    logic        det_load;
    logic [31:0] det_cause, det_target;
    logic        stall, flush, mepc_we, mcause_we, st_trap, st_mret, redir_vld;
    logic [31:0] mepc_o, mcause_o, redir_pc;

    always_comb begin
        state_nxt  = state;
        det_load   = 1'b0;
        det_cause  = 32'd0;
        det_target = 32'd0;
        stall      = 1'b1;
        flush      = 1'b0;
        mepc_we    = 1'b0;
        mcause_we  = 1'b0;
        st_trap    = 1'b0;
        st_mret    = 1'b0;
        redir_vld  = 1'b0;
        mepc_o     = 32'd0;
        mcause_o   = 32'd0;
        redir_pc   = 32'd0;
        case (state)
            ST_IDLE: begin
                stall = 1'b0;
                if (bus.instr_valid_in) begin
                    if (bus.exception_in) begin
                        det_load   = 1'b1;
                        det_cause  = {28'd0, bus.exc_cause_in};
                        det_target = mtvec_base;
                        state_nxt  = ST_FLUSH;
                    end else if (irq_take) begin
                        det_load   = 1'b1;
                        det_cause  = {1'b1, 27'd0, irq_code};
                        det_target = mtvec_base + vec_offset;
                        state_nxt  = ST_FLUSH;
                    end else if (bus.mret_in) begin
                        det_load   = 1'b1;
                        det_target = bus.mepc_in & ~32'd3;
                        state_nxt  = ST_MRET_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = ST_SAVE;
            end
            ST_SAVE: begin
                mepc_we   = 1'b1;
                mcause_we = 1'b1;
                st_trap   = 1'b1;
                mepc_o    = mepc_q;
                mcause_o  = cause_q;
                state_nxt = ST_REDIRECT;
            end
            ST_MRET_FLUSH: begin
                flush     = 1'b1;
                st_mret   = 1'b1;
                state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redir_vld = 1'b1;
                redir_pc  = target_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            cause_q  <= 32'd0;
            mepc_q   <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (det_load) begin
                cause_q  <= det_cause;
                mepc_q   <= bus.pc_in & ~32'd3;
                target_q <= det_target;
            end
        end
    end

    assign bus.mip_out            = mip_word(ext_sync, timer_sync, sw_sync);
    assign bus.stall_out          = stall;
    assign bus.flush_out          = flush;
    assign bus.mepc_wr_en_out     = mepc_we;
    assign bus.mepc_out           = mepc_o;
    assign bus.mcause_wr_en_out   = mcause_we;
    assign bus.mcause_out         = mcause_o;
    assign bus.mstatus_trap_out   = st_trap;
    assign bus.mstatus_mret_out   = st_mret;
    assign bus.redirect_valid_out = redir_vld;
    assign bus.redirect_pc_out    = redir_pc;
endmodule
